adam_uart_loader: RTL and testbench



---
 rtl/adam_uart_loader_pkg.sv | 26 ++
 rtl/adam_uart_loader_if.sv | 26 ++
 rtl/adam_uart_loader_rx.sv | 118 +++++++++++
 rtl/adam_uart_loader.sv | 242 ++++++++++++++++++++++++
 tb/tb_adam_uart_loader.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/adam_uart_loader_pkg.sv
// Shared constants and helpers for the UART boot loader and its receiver.
package adam_uart_loader_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_HDR     = 3'd1;
  localparam state_t ST_COLLECT = 3'd2;
  localparam state_t ST_WR      = 3'd3;
  localparam state_t ST_RESP    = 3'd4;
  localparam state_t ST_CSUM    = 3'd5;
  localparam state_t ST_FIN     = 3'd6;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] HDR_BYTES     = 3'd6;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  function automatic logic [15:0] mid_sample(input int unsigned baud_div);
    return 16'(baud_div / 32'd2);
  endfunction

endpackage

// File: rtl/adam_uart_loader_if.sv
// AXI-Lite write-side bundle between the loader (master) and the RAM (slave).
interface adam_uart_loader_if #(parameter int ADDR_WIDTH = 32);
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [2:0]            aw_prot;
  logic                  aw_valid;
  logic                  aw_ready;
  logic [31:0]           w_data;
  logic [3:0]            w_strb;
  logic                  w_valid;
  logic                  w_ready;
  logic [1:0]            b_resp;
  logic                  b_valid;
  logic                  b_ready;
  logic                  ar_valid;
  logic                  r_ready;

  modport master (
    output aw_addr, aw_prot, aw_valid, w_data, w_strb, w_valid, b_ready, ar_valid, r_ready,
    input  aw_ready, w_ready, b_resp, b_valid
  );

  modport slave (
    input  aw_addr, aw_prot, aw_valid, w_data, w_strb, w_valid, b_ready, ar_valid, r_ready,
    output aw_ready, w_ready, b_resp, b_valid
  );
endinterface

// File: rtl/adam_uart_loader_rx.sv
// UART 8N1 receiver with a one-byte holding register; err_o pulses on framing error or overrun.
module adam_uart_loader_rx
  import adam_uart_loader_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  input  logic       pop_i,
  output logic [7:0] byte_o,
  output logic       valid_o,
  output logic       err_o
);
  localparam logic [15:0] MID_LAST = mid_sample(BAUD_DIV) - 16'd1;
  localparam logic [15:0] BIT_LAST = 16'(BAUD_DIV - 32'd1);

  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  logic [1:0]  rx_state_q, rx_state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_valid_q, hold_valid_d;
  logic        err_q, err_d;

  // Synchronizer plus a delayed copy so only a true high-to-low edge starts a byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Bit-level receive state machine and holding-register update
  always_comb begin
    rx_state_d   = rx_state_q;
    cnt_d        = cnt_q + 16'd1;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q & ~pop_i;
    err_d        = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        cnt_d = 16'd0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
        else                         rx_state_d = RX_IDLE;
      end
      RX_START: begin
        if (cnt_q == MID_LAST) begin
          cnt_d      = 16'd0;
          bit_idx_d  = 3'd0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_state_d = RX_START;
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d      = 16'd0;
          shift_d    = {rx_sync_q, shift_q[7:1]};
          bit_idx_d  = bit_idx_q + 3'd1;
          rx_state_d = (bit_idx_q == 3'd7) ? RX_STOP : RX_DATA;
        end else begin
          rx_state_d = RX_DATA;
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d      = 16'd0;
          rx_state_d = RX_IDLE;
          if (!rx_sync_q) begin
            err_d = 1'b1;
          end else if (hold_valid_q && !pop_i) begin
            err_d = 1'b1;
          end else begin
            hold_d       = shift_q;
            hold_valid_d = 1'b1;
          end
        end else begin
          rx_state_d = RX_STOP;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Receiver state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q   <= RX_IDLE;
      cnt_q        <= 16'd0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'd0;
      hold_q       <= 8'd0;
      hold_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      err_q        <= err_d;
    end
  end

  assign byte_o  = hold_q;
  assign valid_o = hold_valid_q;
  assign err_o   = err_q;
endmodule

// File: rtl/adam_uart_loader.sv
// UART boot loader: parses SYNC/ADDR/LEN/data frames into AXI-Lite word writes.
// Define ADAM_UART_LOADER_CHECKSUM_EN to require a 32-bit sum trailer after the data.
module adam_uart_loader
  import adam_uart_loader_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter int unsigned BAUD_DIV   = 434,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                uart_rx,
  adam_uart_loader_if.master  axil,
  output logic                hold_rst,
  output logic                busy,
  output logic                done,
  output logic                err
);
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           len_q, len_d;
  logic [31:0]           word_q, word_d;
  logic [47:0]           hdr_q, hdr_d;
  logic [2:0]            byte_cnt_q, byte_cnt_d;
  logic                  aw_valid_q, aw_valid_d, w_valid_q, w_valid_d, b_ready_q, b_ready_d;
  logic                  busy_q, busy_d, done_q, done_d, err_q, err_d, hold_rst_q, hold_rst_d;
`ifdef ADAM_UART_LOADER_CHECKSUM_EN
  logic [31:0]           csum_q, csum_d;
  localparam state_t     ST_END = ST_CSUM;
`else
  localparam state_t     ST_END = ST_FIN;
`endif

  logic [7:0]  rx_byte_s;
  logic        rx_valid_s, rx_err_s, pop_s;
  logic [47:0] hdr_full_s;
  logic [31:0] word_next_s;

  adam_uart_loader_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk     (clk),
    .rst     (rst),
    .rx_i    (uart_rx),
    .pop_i   (pop_s),
    .byte_o  (rx_byte_s),
    .valid_o (rx_valid_s),
    .err_o   (rx_err_s)
  );

  // The holding register is drained only while the FSM is waiting for bytes
  always_comb begin
    case (state_q)
      ST_IDLE, ST_HDR, ST_COLLECT: pop_s = rx_valid_s;
`ifdef ADAM_UART_LOADER_CHECKSUM_EN
      ST_CSUM:                     pop_s = rx_valid_s;
`endif
      default:                     pop_s = 1'b0;
    endcase
  end

  assign hdr_full_s  = {rx_byte_s, hdr_q[47:8]};
  assign word_next_s = {rx_byte_s, word_q[31:8]};

  // Frame-level FSM; fields arrive LSB first so bytes shift in from the top
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    word_d     = word_q;
    hdr_d      = hdr_q;
    byte_cnt_d = byte_cnt_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    b_ready_d  = b_ready_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    hold_rst_d = hold_rst_q;
`ifdef ADAM_UART_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pop_s && (rx_byte_s == SYNC_BYTE)) begin
          state_d    = ST_HDR;
          err_d      = 1'b0;
          busy_d     = 1'b1;
          hold_rst_d = 1'b1;
          byte_cnt_d = 3'd0;
`ifdef ADAM_UART_LOADER_CHECKSUM_EN
          csum_d     = 32'd0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (pop_s) begin
          hdr_d      = hdr_full_s;
          byte_cnt_d = byte_cnt_q + 3'd1;
          if (byte_cnt_q == (HDR_BYTES - 3'd1)) begin
            byte_cnt_d = 3'd0;
            addr_d     = ADDR_WIDTH'({hdr_full_s[31:2], 2'b00});
            len_d      = hdr_full_s[47:32];
            state_d    = (hdr_full_s[47:32] == 16'd0) ? ST_END : ST_COLLECT;
          end else begin
            state_d = ST_HDR;
          end
        end else begin
          state_d = ST_HDR;
        end
      end
      ST_COLLECT: begin
        if (pop_s) begin
          word_d     = word_next_s;
          byte_cnt_d = byte_cnt_q + 3'd1;
          if (byte_cnt_q == 3'd3) begin
            byte_cnt_d = 3'd0;
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            state_d    = ST_WR;
          end else begin
            state_d = ST_COLLECT;
          end
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_WR: begin
        if (aw_valid_q && axil.aw_ready) aw_valid_d = 1'b0;
        else                             aw_valid_d = aw_valid_q;
        if (w_valid_q && axil.w_ready)   w_valid_d = 1'b0;
        else                             w_valid_d = w_valid_q;
        if ((!aw_valid_q || axil.aw_ready) && (!w_valid_q || axil.w_ready)) begin
          b_ready_d = 1'b1;
          state_d   = ST_RESP;
        end else begin
          state_d = ST_WR;
        end
      end
      ST_RESP: begin
        if (b_ready_q && axil.b_valid) begin
          b_ready_d = 1'b0;
          if (axil.b_resp != AXI_RESP_OKAY) err_d = 1'b1;
          else                              err_d = err_q;
          addr_d  = addr_q + ADDR_WIDTH'(32'd4);
          len_d   = len_q - 16'd1;
`ifdef ADAM_UART_LOADER_CHECKSUM_EN
          csum_d  = csum_q + word_q;
`endif
          state_d = (len_q == 16'd1) ? ST_END : ST_COLLECT;
        end else begin
          state_d = ST_RESP;
        end
      end
`ifdef ADAM_UART_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (pop_s) begin
          word_d     = word_next_s;
          byte_cnt_d = byte_cnt_q + 3'd1;
          if (byte_cnt_q == 3'd3) begin
            byte_cnt_d = 3'd0;
            if (word_next_s != csum_q) err_d = 1'b1;
            else                       err_d = err_q;
            state_d = ST_FIN;
          end else begin
            state_d = ST_CSUM;
          end
        end else begin
          state_d = ST_CSUM;
        end
      end
`endif
      ST_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
`ifdef ADAM_UART_LOADER_CHECKSUM_EN
        hold_rst_d = err_q;
`else
        hold_rst_d = 1'b0;
`endif
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Receiver errors are sticky regardless of frame state
    if (rx_err_s) err_d = 1'b1;
    else          err_d = err_d;
  end

  // Loader state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      len_q      <= 16'd0;
      word_q     <= 32'd0;
      hdr_q      <= 48'd0;
      byte_cnt_q <= 3'd0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      b_ready_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      hold_rst_q <= 1'b1;
`ifdef ADAM_UART_LOADER_CHECKSUM_EN
      csum_q     <= 32'd0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      word_q     <= word_d;
      hdr_q      <= hdr_d;
      byte_cnt_q <= byte_cnt_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      b_ready_q  <= b_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      hold_rst_q <= hold_rst_d;
`ifdef ADAM_UART_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign axil.aw_addr  = addr_q;
  assign axil.aw_prot  = 3'b000;
  assign axil.aw_valid = aw_valid_q;
  assign axil.w_data   = word_q;
  assign axil.w_strb   = 4'hF;
  assign axil.w_valid  = w_valid_q;
  assign axil.b_ready  = b_ready_q;
  assign axil.ar_valid = 1'b0;
  assign axil.r_ready  = 1'b0;
  assign hold_rst      = hold_rst_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
endmodule

// File: tb/tb_adam_uart_loader.sv
// Self-checking bench: serial frames in, AXI-Lite writes compared against a frame-level model.
module tb_adam_uart_loader;
  localparam int BAUD = 16;

  logic clk = 1'b0;
  logic rst;
  logic uart_rx;
  logic hold_rst, busy, done, err;

  adam_uart_loader_if #(.ADDR_WIDTH(32)) axil();

  adam_uart_loader #(.ADDR_WIDTH(32), .BAUD_DIV(BAUD), .SYNC_BYTE(8'hA5)) dut (
    .clk      (clk),
    .rst      (rst),
    .uart_rx  (uart_rx),
    .axil     (axil),
    .hold_rst (hold_rst),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // AXI-Lite slave responder state
  int aw_delay = 0, w_delay = 0, b_delay = 0, bad_resp_idx = -1;
  int aw_wait = 0, w_wait = 0, b_wait = 0;
  int n_aw = 0, n_w = 0, n_b = 0, done_cnt = 0, viol = 0;
  bit aw_fire = 0, w_fire = 0, b_fire = 0, aw_pend = 0, w_pend = 0;
  logic [31:0] aw_pend_addr, w_pend_data;
  logic [31:0] aw_log[$];
  logic [31:0] w_log[$];
  logic [31:0] words[$];

  // Inputs change on negedge; a handshake is decided here and takes effect at the next posedge
  initial begin : axi_slave
    axil.aw_ready = 1'b0;
    axil.w_ready  = 1'b0;
    axil.b_valid  = 1'b0;
    axil.b_resp   = 2'b00;
    forever begin
      @(negedge clk);
      if (rst) begin
        axil.aw_ready = 1'b0; axil.w_ready = 1'b0; axil.b_valid = 1'b0;
        aw_wait = 0; w_wait = 0; b_wait = 0;
        aw_fire = 0; w_fire = 0; b_fire = 0; aw_pend = 0; w_pend = 0;
      end else begin
        if (done === 1'b1) done_cnt++;
        if (aw_pend && (axil.aw_valid !== 1'b1 || axil.aw_addr !== aw_pend_addr)) viol++;
        if (w_pend && (axil.w_valid !== 1'b1 || axil.w_data !== w_pend_data)) viol++;
        if (aw_fire) begin axil.aw_ready = 1'b0; aw_wait = 0; end
        if (w_fire)  begin axil.w_ready = 1'b0;  w_wait = 0;  end
        if (b_fire)  begin axil.b_valid = 1'b0;  n_b++;       end
        if (!axil.b_valid && n_b < n_aw && n_b < n_w) begin
          if (b_wait >= b_delay) begin
            axil.b_valid = 1'b1;
            axil.b_resp  = (n_b == bad_resp_idx) ? 2'b10 : 2'b00;
            b_wait = 0;
          end else b_wait++;
        end
        if (axil.aw_valid && !axil.aw_ready) begin
          if (aw_wait >= aw_delay) axil.aw_ready = 1'b1; else aw_wait++;
        end
        if (axil.w_valid && !axil.w_ready) begin
          if (w_wait >= w_delay) axil.w_ready = 1'b1; else w_wait++;
        end
        aw_fire = axil.aw_valid && axil.aw_ready;
        w_fire  = axil.w_valid && axil.w_ready;
        if (aw_fire) begin
          aw_log.push_back(axil.aw_addr); n_aw++;
          if (axil.aw_prot !== 3'b000) viol++;
        end
        if (w_fire) begin
          w_log.push_back(axil.w_data); n_w++;
          if (axil.w_strb !== 4'hF) viol++;
        end
        aw_pend = axil.aw_valid && !axil.aw_ready; aw_pend_addr = axil.aw_addr;
        w_pend  = axil.w_valid && !axil.w_ready;   w_pend_data  = axil.w_data;
        b_fire  = axil.b_valid && axil.b_ready;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    uart_rx = 1'b0; repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i]; repeat (BAUD) @(negedge clk);
    end
    uart_rx = bad_stop ? 1'b0 : 1'b1; repeat (BAUD) @(negedge clk);
    uart_rx = 1'b1; repeat (BAUD / 2 + $urandom_range(0, 8)) @(negedge clk);
  endtask

  task automatic clear_logs();
    aw_log.delete(); w_log.delete();
    n_aw = 0; n_w = 0; n_b = 0; done_cnt = 0; viol = 0;
  endtask

  // Frame-level model: expected writes are base (low bits cleared) + 4*i, data in order
  task automatic run_frame(input string name, input logic [31:0] addr, input int bad_stop_pos,
                           input int bad_resp, input bit bad_csum, input int awd, input int wd, input int bd);
    logic [7:0]  bytes[$];
    logic [31:0] sum, ea, base;
    logic [15:0] len16;
    bit exp_err, exp_hold;
    int len, t;
    len = words.size();
    len16 = 16'(len);
    sum = 32'd0;
    bytes.push_back(8'hA5);
    for (int i = 0; i < 4; i++) bytes.push_back(addr[8*i +: 8]);
    bytes.push_back(len16[7:0]);
    bytes.push_back(len16[15:8]);
    foreach (words[k]) begin
      for (int j = 0; j < 4; j++) bytes.push_back(words[k][8*j +: 8]);
      sum = sum + words[k];
    end
    exp_err = (bad_stop_pos >= 0) || (bad_resp >= 0 && bad_resp < len);
`ifdef ADAM_UART_LOADER_CHECKSUM_EN
    if (bad_csum) sum = sum ^ 32'h0000_0001;
    for (int j = 0; j < 4; j++) bytes.push_back(sum[8*j +: 8]);
    exp_err  = exp_err || bad_csum;
    exp_hold = exp_err;
`else
    if (bad_csum) $display("note: trailer corruption ignored in this build");
    exp_hold = 1'b0;
`endif
    clear_logs();
    aw_delay = awd; w_delay = wd; b_delay = bd; bad_resp_idx = bad_resp;
    foreach (bytes[i]) begin
      if (i == bad_stop_pos) send_byte(bytes[i], 1'b1);
      send_byte(bytes[i], 1'b0);
      if (i == 0) begin
        check_eq({name, ":busy_after_sync"}, busy, 1);
        check_eq({name, ":hold_after_sync"}, hold_rst, 1);
        check_eq({name, ":err_cleared_by_sync"}, err, 0);
      end
    end
    t = 0;
    while (done_cnt == 0 && t < 4000) begin @(negedge clk); t++; end
    check_eq({name, ":done_seen_in_time"}, (t < 4000), 1);
    repeat (4) @(negedge clk);
    check_eq({name, ":done_pulses"}, done_cnt, 1);
    check_eq({name, ":aw_count"}, n_aw, len);
    check_eq({name, ":w_count"}, n_w, len);
    base = {addr[31:2], 2'b00};
    for (int i = 0; i < len; i++) begin
      ea = base + 32'(4 * i);
      if (i < aw_log.size()) check_eq($sformatf("%s:aw_addr[%0d]", name, i), aw_log[i], ea);
      if (i < w_log.size())  check_eq($sformatf("%s:w_data[%0d]", name, i), w_log[i], words[i]);
    end
    check_eq({name, ":protocol"}, viol, 0);
    check_eq({name, ":err"}, err, exp_err);
    check_eq({name, ":hold_rst"}, hold_rst, exp_hold);
    check_eq({name, ":busy_end"}, busy, 0);
  endtask

  logic [7:0]  rbytes[$];
  logic [31:0] raddr;
  int t;

  initial begin : main
    rst = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst:aw_valid", axil.aw_valid, 0);
    check_eq("rst:w_valid", axil.w_valid, 0);
    check_eq("rst:b_ready", axil.b_ready, 0);
    check_eq("rst:aw_addr", axil.aw_addr, 0);
    check_eq("rst:w_data", axil.w_data, 0);
    check_eq("rst:busy", busy, 0);
    check_eq("rst:done", done, 0);
    check_eq("rst:err", err, 0);
    check_eq("rst:hold_rst", hold_rst, 1);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    words = '{32'h1122_3344, 32'hDEAD_BEEF};
    run_frame("A", 32'h0000_0102, -1, -1, 1'b0, 0, 0, 0);
    run_frame("B_slow", 32'h0000_0102, -1, -1, 1'b0, 5, 0, 3);

    words.delete();
    run_frame("len0", 32'h0000_0040, -1, -1, 1'b0, 0, 0, 0);

    // Short low glitch and a stray non-sync byte must both be ignored while idle
    clear_logs();
    uart_rx = 1'b0; repeat (3) @(negedge clk); uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    send_byte(8'h5A, 1'b0);
    repeat (10) @(negedge clk);
    check_eq("idle:err", err, 0);
    check_eq("idle:busy", busy, 0);
    check_eq("idle:aw_count", n_aw, 0);

    words = '{$urandom, $urandom};
    run_frame("wrap", 32'hFFFF_FFFC, -1, -1, 1'b0, 1, 2, 0);

    words = '{$urandom, $urandom, $urandom};
    run_frame("errs", 32'h0000_0300, 2, 1, 1'b0, 0, 1, 1);
    repeat (20) @(negedge clk);
    check_eq("err_sticky", err, 1);

    words = '{32'hA5A5_A5A5, 32'h0000_00A5};
    run_frame("sync_as_data", 32'h0000_1000, -1, -1, 1'b0, 2, 0, 1);

    for (int f = 0; f < 4; f++) begin
      words.delete();
      repeat ($urandom_range(1, 3)) words.push_back($urandom);
      run_frame($sformatf("rand%0d", f), $urandom, -1, -1, 1'b0,
                $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 4));
    end

    // Abort in WR: AW is never accepted, then rst hits mid-cycle
    clear_logs();
    aw_delay = 1000000; w_delay = 0; b_delay = 0; bad_resp_idx = -1;
    raddr = 32'h0000_0200;
    rbytes.delete();
    rbytes.push_back(8'hA5);
    for (int i = 0; i < 4; i++) rbytes.push_back(raddr[8*i +: 8]);
    rbytes.push_back(8'h01); rbytes.push_back(8'h00);
    rbytes.push_back(8'h0D); rbytes.push_back(8'hF0); rbytes.push_back(8'hAD); rbytes.push_back(8'h0B);
    foreach (rbytes[i]) send_byte(rbytes[i], 1'b0);
    t = 0;
    while (axil.aw_valid !== 1'b1 && t < 500) begin @(negedge clk); t++; end
    check_eq("abort:aw_valid_seen", (t < 500), 1);
    #2 rst = 1'b1;
    #1;
    check_eq("abort:aw_valid", axil.aw_valid, 0);
    check_eq("abort:w_valid", axil.w_valid, 0);
    check_eq("abort:b_ready", axil.b_ready, 0);
    check_eq("abort:aw_addr", axil.aw_addr, 0);
    check_eq("abort:w_data", axil.w_data, 0);
    check_eq("abort:busy", busy, 0);
    check_eq("abort:err", err, 0);
    check_eq("abort:hold_rst", hold_rst, 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    words = '{32'hCAFE_0001};
    run_frame("after_abort", 32'h0000_0200, -1, -1, 1'b0, 0, 0, 0);

`ifdef ADAM_UART_LOADER_CHECKSUM_EN
    words = '{32'h0102_0304, 32'h0A0B_0C0D};
    run_frame("bad_csum", 32'h0000_0500, -1, -1, 1'b1, 0, 0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
